// File: rtl/unet_pkg.sv
// unet_pkg: status codes, sequencer/core state encodings and frame geometry
// shared by the U-Net stage 3_1 sequencer and its compute core.
package unet_pkg;

    localparam int DW        = 32;
    localparam int CNT_W     = 17;
    localparam int W_WORDS   = 939;
    localparam int IN_WORDS  = 98369;
    localparam int OUT_WORDS = 65536;

    localparam logic [2:0] SAY_CALCULATING  = 3'd0;
    localparam logic [2:0] SAY_SEND_WEIGHTS = 3'd1;
    localparam logic [2:0] SAY_SEND_DATA    = 3'd2;
    localparam logic [2:0] SAY_DATA_READY   = 3'd3;
    localparam logic [2:0] SAY_SENDING      = 3'd4;
    localparam logic [2:0] SAY_IDLE         = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_D,
        S_CALC,
        S_READY,
        S_SEND
    } state_t;

    typedef enum logic {
        C_IDLE,
        C_RUN
    } core_state_t;

    // Depth-1 memories still need a one-bit address.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic [2:0] ctrl_code(input state_t s);
        logic [2:0] code;
        code = SAY_IDLE;
        case (s)
            S_IDLE:   code = SAY_IDLE;
            S_LOAD_W: code = SAY_SEND_WEIGHTS;
            S_LOAD_D: code = SAY_SEND_DATA;
            S_CALC:   code = SAY_CALCULATING;
            S_READY:  code = SAY_DATA_READY;
            S_SEND:   code = SAY_SENDING;
            default:  code = SAY_IDLE;
        endcase
        return code;
    endfunction

    function automatic logic is_busy(input state_t s);
        return (s == S_LOAD_W) || (s == S_LOAD_D) || (s == S_CALC) || (s == S_SEND);
    endfunction

endpackage

// File: rtl/unet_compute_core.sv
// unet_compute_core: applies the stored weights element-wise to the frame,
// writing omem[k] = imem[k mod NUM_IN] + wmem[k mod NUM_W] for every output word.
module unet_compute_core
    import unet_pkg::*;
#(
    parameter int NUM_W   = W_WORDS,
    parameter int NUM_IN  = IN_WORDS,
    parameter int NUM_OUT = OUT_WORDS,
    localparam int WAW    = addr_width(NUM_W),
    localparam int IAW    = addr_width(NUM_IN),
    localparam int OAW    = addr_width(NUM_OUT)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           done,
    output logic [WAW-1:0] wmem_addr,
    input  logic [DW-1:0]  wmem_data,
    output logic [IAW-1:0] imem_addr,
    input  logic [DW-1:0]  imem_data,
    output logic           omem_we,
    output logic [OAW-1:0] omem_addr,
    output logic [DW-1:0]  omem_data
);

    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(NUM_OUT - 1);
    localparam logic [WAW-1:0]   W_LAST   = WAW'(NUM_W - 1);
    localparam logic [IAW-1:0]   IN_LAST  = IAW'(NUM_IN - 1);
    localparam logic [OAW-1:0]   OUT_LAST = OAW'(NUM_OUT - 1);

    core_state_t      cstate, cstate_nxt;
    logic [CNT_W-1:0] idx, idx_nxt;
    logic [WAW-1:0]   widx, widx_nxt;
    logic [IAW-1:0]   iidx, iidx_nxt;
    logic             issue;
    logic             pend;
    logic [OAW-1:0]   pend_addr;

    // widx/iidx track idx modulo the memory depths without a divider.
    always_comb begin
        cstate_nxt = cstate;
        idx_nxt    = idx;
        widx_nxt   = widx;
        iidx_nxt   = iidx;
        issue      = 1'b0;
        unique case (cstate)
            C_IDLE: begin
                if (start) begin
                    cstate_nxt = C_RUN;
                    idx_nxt    = '0;
                    widx_nxt   = '0;
                    iidx_nxt   = '0;
                end
            end
            C_RUN: begin
                issue = 1'b1;
                if (idx == IDX_LAST) begin
                    cstate_nxt = C_IDLE;
                end else begin
                    idx_nxt  = idx + CNT_W'(1);
                    widx_nxt = (widx == W_LAST) ? '0 : widx + WAW'(1);
                    iidx_nxt = (iidx == IN_LAST) ? '0 : iidx + IAW'(1);
                end
            end
            default: cstate_nxt = C_IDLE;
        endcase
    end

    // done trails the final omem write by a cycle so omem is complete when it fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            cstate    <= C_IDLE;
            idx       <= '0;
            widx      <= '0;
            iidx      <= '0;
            pend      <= 1'b0;
            pend_addr <= '0;
            done      <= 1'b0;
        end else begin
            cstate    <= cstate_nxt;
            idx       <= idx_nxt;
            widx      <= widx_nxt;
            iidx      <= iidx_nxt;
            pend      <= issue;
            pend_addr <= idx[OAW-1:0];
            done      <= pend && (pend_addr == OUT_LAST);
        end
    end

    assign wmem_addr = widx;
    assign imem_addr = iidx;
    assign omem_we   = pend;
    assign omem_addr = pend_addr;
    assign omem_data = wmem_data + imem_data;

endmodule

// File: rtl/unet_fsm_3_1.sv
// unet_fsm_3_1: host-facing sequencer for U-Net stage 3_1. Streams in weights and a
// frame, runs unet_compute_core over them, then streams the packed result back out.
module unet_fsm_3_1
    import unet_pkg::*;
#(
    parameter int NUM_W   = W_WORDS,
    parameter int NUM_IN  = IN_WORDS,
    parameter int NUM_OUT = OUT_WORDS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          unet_enpulse,
    input  logic [DW-1:0] data_in,
    output logic [2:0]    ctrl,
    output logic          busy,
    output logic [DW-1:0] data_out
);

    localparam int WAW = addr_width(NUM_W);
    localparam int IAW = addr_width(NUM_IN);
    localparam int OAW = addr_width(NUM_OUT);

    localparam logic [CNT_W-1:0] W_LAST   = CNT_W'(NUM_W - 1);
    localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(NUM_IN - 1);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(NUM_OUT - 1);
    localparam logic [CNT_W-1:0] OUT_END  = CNT_W'(NUM_OUT);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             wloaded, wloaded_nxt;
    logic             en_prev;
    logic             rise;
    logic             core_start, core_start_nxt;
    logic             core_done;
    logic             wmem_we;
    logic             imem_we;
    logic             dout_load;
    logic             dout_clear;
    logic [OAW-1:0]   dout_addr;

    logic [DW-1:0]    wmem [NUM_W];
    logic [DW-1:0]    imem [NUM_IN];
    logic [DW-1:0]    omem [NUM_OUT];

    logic [WAW-1:0]   wmem_raddr;
    logic [DW-1:0]    wmem_rdata;
    logic [IAW-1:0]   imem_raddr;
    logic [DW-1:0]    imem_rdata;
    logic             omem_we;
    logic [OAW-1:0]   omem_waddr;
    logic [DW-1:0]    omem_wdata;

    assign rise = unet_enpulse & ~en_prev;

    // The host only gets a say in IDLE and READY; every other phase runs to completion.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        wloaded_nxt    = wloaded;
        core_start_nxt = 1'b0;
        wmem_we        = 1'b0;
        imem_we        = 1'b0;
        dout_load      = 1'b0;
        dout_clear     = 1'b0;
        dout_addr      = cnt[OAW-1:0] + OAW'(1);
        unique case (state)
            S_IDLE: begin
                if (rise) begin
                    state_nxt = wloaded ? S_LOAD_D : S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                wmem_we = 1'b1;
                if (cnt == W_LAST) begin
                    cnt_nxt     = '0;
                    wloaded_nxt = 1'b1;
                    state_nxt   = S_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_LOAD_D: begin
                imem_we = 1'b1;
                if (cnt == IN_LAST) begin
                    cnt_nxt        = '0;
                    core_start_nxt = 1'b1;
                    state_nxt      = S_CALC;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_CALC: begin
                if (core_done) begin
                    state_nxt = S_READY;
                    dout_load = 1'b1;
                    dout_addr = '0;
                end
            end
            S_READY: begin
                if (rise) begin
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                // data_out already shows word cnt; fetch the next one or blank for the tail cycle.
                if (cnt == OUT_END) begin
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == OUT_LAST) begin
                        dout_clear = 1'b1;
                    end else begin
                        dout_load = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            wloaded    <= 1'b0;
            en_prev    <= 1'b0;
            core_start <= 1'b0;
            ctrl       <= SAY_IDLE;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            wloaded    <= wloaded_nxt;
            en_prev    <= unet_enpulse;
            core_start <= core_start_nxt;
            ctrl       <= ctrl_code(state_nxt);
            busy       <= is_busy(state_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (wmem_we) begin
            wmem[cnt[WAW-1:0]] <= data_in;
        end
        wmem_rdata <= wmem[wmem_raddr];
    end

    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[cnt[IAW-1:0]] <= data_in;
        end
        imem_rdata <= imem[imem_raddr];
    end

    always_ff @(posedge clk) begin
        if (omem_we) begin
            omem[omem_waddr] <= omem_wdata;
        end
    end

    // data_out doubles as the omem read register, so the preload in CALC hides read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
        end else if (dout_load) begin
            data_out <= omem[dout_addr];
        end else if (dout_clear) begin
            data_out <= '0;
        end
    end

    unet_compute_core #(
        .NUM_W   (NUM_W),
        .NUM_IN  (NUM_IN),
        .NUM_OUT (NUM_OUT)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (core_start),
        .done      (core_done),
        .wmem_addr (wmem_raddr),
        .wmem_data (wmem_rdata),
        .imem_addr (imem_raddr),
        .imem_data (imem_rdata),
        .omem_we   (omem_we),
        .omem_addr (omem_waddr),
        .omem_data (omem_wdata)
    );

endmodule

// File: tb/tb_unet_fsm_3_1.sv
// tb_unet_fsm_3_1: self-checking bench for the stage 3_1 sequencer, run with reduced
// frame geometry so every phase (load, calc, readout, abort) is exercised end to end.
module tb_unet_fsm_3_1;
    import unet_pkg::*;

    localparam int TB_W       = 5;
    localparam int TB_IN      = 9;
    localparam int TB_OUT     = 12;
    localparam int CALC_LIMIT = 20 * TB_OUT + 50;
    localparam int N_VEC      = TB_W + 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          unet_enpulse;
    logic [DW-1:0] data_in;
    logic [2:0]    ctrl;
    logic          busy;
    logic [DW-1:0] data_out;

    int total = 0;
    int bad   = 0;

    logic [31:0] w_ref  [TB_W];
    logic [31:0] in_ref [TB_IN];
    logic [31:0] word_q [$];

    typedef struct {
        logic        rst;
        logic        en;
        logic [31:0] din;
        logic [2:0]  exp_ctrl;
        logic        exp_busy;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs [N_VEC];

    unet_fsm_3_1 #(
        .NUM_W   (TB_W),
        .NUM_IN  (TB_IN),
        .NUM_OUT (TB_OUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .unet_enpulse (unet_enpulse),
        .data_in      (data_in),
        .ctrl         (ctrl),
        .busy         (busy),
        .data_out     (data_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, actual, required);
        end
    endtask

    // Result word k is frame word (k mod frame length) plus weight (k mod weight count).
    function automatic logic [31:0] exp_word(input int k);
        return in_ref[k % TB_IN] + w_ref[k % TB_W];
    endfunction

    task automatic load_phase(input logic [2:0] code, input int n, input bit hold_en, input string tag);
        int seen;
        seen = 0;
        for (int k = 0; k < n; k++) begin
            data_in      = word_q[k];
            unet_enpulse = hold_en ? 1'b1 : 1'($urandom_range(0, 1));
            if (ctrl == code && busy) seen++;
            tick();
        end
        check_output({tag, "_cycles"}, 32'(seen), 32'(n));
    endtask

    task automatic load_weights_random(input string tag);
        word_q.delete();
        for (int k = 0; k < TB_W; k++) word_q.push_back($urandom());
        load_phase(SAY_SEND_WEIGHTS, TB_W, 1'b0, tag);
        unet_enpulse = 1'b0;
        check_output({tag, "_exit_ctrl"}, 32'(ctrl), 32'(SAY_IDLE));
        check_output({tag, "_exit_busy"}, 32'(busy), 32'(1'b0));
        for (int k = 0; k < TB_W; k++) w_ref[k] = word_q[k];
        tick();
        check_output({tag, "_idle_hold"}, 32'(ctrl), 32'(SAY_IDLE));
    endtask

    task automatic run_frame(input string tag, input bit hold_en, input bit fixed);
        int cyc;
        int anomalies;
        int n_wait;
        word_q.delete();
        for (int k = 0; k < TB_IN; k++) word_q.push_back(fixed ? 32'hA5A5_0000 + 32'(k) : $urandom());
        unet_enpulse = 1'b0;
        tick();
        check_output({tag, "_pre_idle"}, 32'(ctrl), 32'(SAY_IDLE));
        unet_enpulse = 1'b1;
        tick();
        check_output({tag, "_enter_ctrl"}, 32'(ctrl), 32'(SAY_SEND_DATA));
        check_output({tag, "_enter_busy"}, 32'(busy), 32'(1'b1));
        load_phase(SAY_SEND_DATA, TB_IN, hold_en, {tag, "_load"});
        for (int k = 0; k < TB_IN; k++) in_ref[k] = word_q[k];
        check_output({tag, "_calc_ctrl"}, 32'(ctrl), 32'(SAY_CALCULATING));

        cyc       = 0;
        anomalies = 0;
        while (ctrl == SAY_CALCULATING && cyc < CALC_LIMIT) begin
            if (!busy) anomalies++;
            unet_enpulse = hold_en ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        check_output({tag, "_calc_busy_gaps"}, 32'(anomalies), 32'd0);
        check_output({tag, "_ready_ctrl"}, 32'(ctrl), 32'(SAY_DATA_READY));
        if (ctrl != SAY_DATA_READY) return;
        check_output({tag, "_ready_busy"}, 32'(busy), 32'(1'b0));
        check_output({tag, "_ready_dout"}, data_out, exp_word(0));

        n_wait = hold_en ? 3 : int'($urandom_range(1, 3));
        for (int i = 0; i < n_wait; i++) begin
            unet_enpulse = hold_en;
            tick();
            check_output($sformatf("%s_ready_wait%0d", tag, i), 32'(ctrl), 32'(SAY_DATA_READY));
        end
        unet_enpulse = 1'b0;
        tick();
        check_output({tag, "_ready_last"}, 32'(ctrl), 32'(SAY_DATA_READY));
        unet_enpulse = 1'b1;
        tick();

        for (int k = 0; k < TB_OUT; k++) begin
            check_output($sformatf("%s_send_ctrl%0d", tag, k), 32'(ctrl), 32'(SAY_SENDING));
            check_output($sformatf("%s_word%0d", tag, k), data_out, exp_word(k));
            unet_enpulse = 1'($urandom_range(0, 1));
            tick();
        end
        check_output({tag, "_tail_ctrl"}, 32'(ctrl), 32'(SAY_SENDING));
        check_output({tag, "_tail_dout"}, data_out, 32'd0);
        unet_enpulse = 1'b0;
        tick();
        check_output({tag, "_end_ctrl"}, 32'(ctrl), 32'(SAY_IDLE));
        check_output({tag, "_end_busy"}, 32'(busy), 32'(1'b0));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        unet_enpulse = 1'b0;
        data_in      = '0;

        // Reset, then a weight load with data_in = k and the request held for two cycles.
        vecs[0] = '{1'b1, 1'b0, 32'd0, SAY_IDLE, 1'b0, 32'd0};
        vecs[1] = '{1'b0, 1'b0, 32'd0, SAY_IDLE, 1'b0, 32'd0};
        vecs[2] = '{1'b0, 1'b1, 32'd0, SAY_SEND_WEIGHTS, 1'b1, 32'd0};
        for (int k = 0; k < TB_W; k++) begin
            vecs[3 + k] = '{1'b0, (k == 0), 32'(k),
                            (k == TB_W - 1) ? SAY_IDLE : SAY_SEND_WEIGHTS,
                            (k != TB_W - 1), 32'd0};
        end
        vecs[3 + TB_W] = '{1'b0, 1'b0, 32'd0, SAY_IDLE, 1'b0, 32'd0};

        for (int i = 0; i < N_VEC; i++) begin
            rst          = vecs[i].rst;
            unet_enpulse = vecs[i].en;
            data_in      = vecs[i].din;
            tick();
            check_output($sformatf("vec%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].exp_ctrl));
            check_output($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            check_output($sformatf("vec%0d_dout", i), data_out, vecs[i].exp_dout);
        end
        for (int k = 0; k < TB_W; k++) w_ref[k] = 32'(k);

        run_frame("f_fixed", 1'b0, 1'b1);
        run_frame("f_hold", 1'b1, 1'b0);
        for (int r = 0; r < 3; r++) run_frame($sformatf("f_rand%0d", r), 1'b0, 1'b0);

        // Reset in the middle of a frame load forces a full weight reload.
        unet_enpulse = 1'b0;
        tick();
        unet_enpulse = 1'b1;
        tick();
        check_output("abort_enter", 32'(ctrl), 32'(SAY_SEND_DATA));
        unet_enpulse = 1'b0;
        for (int k = 0; k < 4; k++) begin
            data_in = $urandom();
            tick();
        end
        check_output("abort_pre", 32'(ctrl), 32'(SAY_SEND_DATA));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("abort_ctrl", 32'(ctrl), 32'(SAY_IDLE));
        check_output("abort_busy", 32'(busy), 32'(1'b0));
        check_output("abort_dout", data_out, 32'd0);
        tick();
        check_output("abort_idle", 32'(ctrl), 32'(SAY_IDLE));
        unet_enpulse = 1'b1;
        tick();
        check_output("abort_reload", 32'(ctrl), 32'(SAY_SEND_WEIGHTS));
        load_weights_random("w2");
        run_frame("f_after_abort", 1'b0, 1'b0);

        // A request arriving with reset is dropped, but still counts as a fresh rise afterwards.
        unet_enpulse = 1'b0;
        tick();
        rst          = 1'b1;
        unet_enpulse = 1'b1;
        tick();
        rst = 1'b0;
        check_output("rstrise_ctrl", 32'(ctrl), 32'(SAY_IDLE));
        tick();
        check_output("rstrise_rise", 32'(ctrl), 32'(SAY_SEND_WEIGHTS));
        load_weights_random("w3");
        run_frame("f_final", 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
